fifo_read_streamer: RTL and testbench

// - Downstream drain stage for the synchronous FIFO: pops words via rd_en and presents them on a valid/ready stream.
// - Hides the FIFO's 1-cycle read latency with a 2-entry output skid buffer; sustains 1 word/cycle when FIFO non-empty and sink ready.
// - Frames output into fixed-length packets (m_last) and flags any FIFO underflow as a sticky error.

---
 rtl/fifo_read_streamer.sv | 123 ++++++++++++
 tb/tb_fifo_read_streamer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_streamer.sv
// Drains a synchronous FIFO into a valid/ready stream through a 2-entry skid buffer,
// frames the output into PKT_LEN-beat packets and latches FIFO underflow. Optional STREAM_STATS_EN adds beat/stall counters.
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int PKT_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
`ifdef STREAM_STATS_EN
  output logic [31:0]           beat_total,
  output logic [31:0]           stall_cycles,
`endif
  output logic                  err_underflow
);

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2} buf_state_t;

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  buf_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  inflight_q;
  logic [15:0]           beat_cnt_q, beat_cnt_d;
  logic                  err_q;
  logic                  pop;
  logic                  wr;
  logic [2:0]            credit;

  assign m_valid       = (state_q != S0);
  assign m_data        = head_q;
  assign m_last        = m_valid & (beat_cnt_q == LAST_IDX);
  assign err_underflow = err_q;
  assign pop           = m_valid & m_ready;
  assign wr            = inflight_q;

  // Occupancy the buffer will have once the in-flight word lands and this cycle's pop leaves.
  assign credit     = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = !rst & !fifo_empty & (credit < 3'd2);

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    beat_cnt_d = beat_cnt_q;
    case ({wr, pop})
      2'b10: begin
        case (state_q)
          S0: begin
            head_d  = fifo_dout;
            state_d = S1;
          end
          S1: begin
            tail_d  = fifo_dout;
            state_d = S2;
          end
          default: ;
        endcase
      end
      2'b01: begin
        head_d  = tail_q;
        state_d = (state_q == S2) ? S1 : S0;
      end
      2'b11: begin
        if (state_q == S2) begin
          head_d = tail_q;
          tail_d = fifo_dout;
        end else begin
          head_d = fifo_dout;
        end
      end
      default: ;
    endcase
    if (pop) begin
      beat_cnt_d = m_last ? 16'd0 : beat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      beat_cnt_q <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= fifo_rd_en;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_q | fifo_underflow;
    end
  end

`ifdef STREAM_STATS_EN
  logic [31:0] beat_total_q;
  logic [31:0] stall_cycles_q;

  assign beat_total   = beat_total_q;
  assign stall_cycles = stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_total_q   <= 32'd0;
      stall_cycles_q <= 32'd0;
    end else begin
      if (pop) beat_total_q <= beat_total_q + 32'd1;
      if (m_valid && !m_ready) stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Directed + random bench for fifo_read_streamer with a behavioural FIFO and an in-order scoreboard.
`timescale 1ns/1ps
module tb_fifo_read_streamer;

  localparam int DW   = 16;
  localparam int PLEN = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          err_underflow;
`ifdef STREAM_STATS_EN
  logic [31:0]   beat_total;
  logic [31:0]   stall_cycles;
`endif

  fifo_read_streamer #(.DATA_WIDTH(DW), .PKT_LEN(PLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
`ifdef STREAM_STATS_EN
    .beat_total    (beat_total),
    .stall_cycles  (stall_cycles),
`endif
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  int fcount = 0;
  int tb_beat = 0;
  int tb_beats = 0;
  int tb_stall = 0;
  int rd_cnt = 0;

  assign fifo_empty = (fcount == 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    sb.push_back(w);
    fcount = fq.size();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", sb.size(), 0);
  endtask

  // Behavioural FIFO: data appears on fifo_dout the cycle after rd_en.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_dout <= fq[0];
      #1;
      void'(fq.pop_front());
      fcount = fq.size();
    end
  end

  // Monitor: inputs settle at posedge+2, so the negedge sees exactly what the next edge accepts.
  always @(negedge clk) begin
    logic [DW-1:0] exp_w;
    logic          exp_last;
    if (rst) begin
      tb_beat  = 0;
      tb_beats = 0;
      tb_stall = 0;
    end else begin
      chk("rd_en_while_empty", {31'd0, fifo_rd_en & fifo_empty}, 0);
      rd_cnt += int'(fifo_rd_en);
      if (m_valid && m_ready) begin
        chk("beat_expected", {31'd0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          exp_w    = sb.pop_front();
          exp_last = (tb_beat == PLEN - 1);
          chk("beat_data", m_data, exp_w);
          chk("beat_last", m_last, exp_last);
          tb_beat  = exp_last ? 0 : tb_beat + 1;
          tb_beats++;
        end
      end
      if (m_valid && !m_ready) tb_stall++;
      $display("cyc t=%0t rd_en=%0b valid=%0b ready=%0b data=%04h last=%0b", $time, fifo_rd_en, m_valid, m_ready, m_data, m_last);
    end
  end

  initial begin
    int pushed;
    int n;
    int k;
    fifo_dout      = '0;
    rst            = 1'b1;
    m_ready        = 1'b0;
    fifo_underflow = 1'b0;
    repeat (3) step();
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_data", m_data, 0);
    chk("rst_err", err_underflow, 0);
    rst = 1'b0;
    step();

    // 16 preloaded words streamed back-to-back; packets end on beats 8 and 16.
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push(i[DW-1:0]);
    #1;
    chk("t1_first_rd_en", fifo_rd_en, 1);
    chk("t1_no_valid_yet", m_valid, 0);
    step();
    step();
    chk("t1_first_data", m_data, 16'h0001);
    for (int i = 0; i < 16; i++) begin
      chk("t1_stream_valid", m_valid, 1);
      step();
    end
    chk("t1_idle_after", m_valid, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // Backpressure: two pops fill the skid buffer, head held stable.
    m_ready = 1'b0;
    rd_cnt  = 0;
    for (int i = 0; i < 4; i++) push(16'hA0 + 16'(i));
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 2) begin
        chk("t2_hold_valid", m_valid, 1);
        chk("t2_hold_data", m_data, 16'h00A0);
      end
    end
    chk("t2_rd_pulses", rd_cnt, 2);
    m_ready = 1'b1;
    wait_drain(20);

    // Empty FIFO with toggling ready: nothing must move.
    for (int i = 0; i < 12; i++) begin
      m_ready = i[0];
      step();
      chk("t3_rd_en", fifo_rd_en, 0);
      chk("t3_valid", m_valid, 0);
      chk("t3_err", err_underflow, 0);
    end

    // Random ready and random FIFO refills.
    pushed = 0;
    n      = 0;
    while ((pushed < 1000 || sb.size() > 0) && n < 30000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (pushed < 1000 && $urandom_range(0, 3) == 0) begin
        k = $urandom_range(1, 8);
        for (int j = 0; j < k && pushed < 1000; j++) begin
          push(16'($urandom_range(0, 65535)));
          pushed++;
        end
      end
      step();
      n++;
    end
    chk("t4_all_delivered", sb.size(), 0);
    chk("t4_all_pushed", pushed, 1000);
`ifdef STREAM_STATS_EN
    chk("t4_beat_total", beat_total, tb_beats);
    chk("t4_stall_cycles", stall_cycles, tb_stall);
`endif

    // Reset with a full skid buffer and a partly sent packet.
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(16'hC0 + 16'(i));
    repeat (5) step();
    m_ready = 1'b0;
    repeat (3) step();
    chk("t5_full_before_rst", m_valid, 1);
    rst = 1'b1;
    fq.delete();
    sb.delete();
    fcount = 0;
    step();
    rst = 1'b0;
    chk("t5_valid", m_valid, 0);
    chk("t5_last", m_last, 0);
    chk("t5_rd_en", fifo_rd_en, 0);
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(16'hD0 + 16'(i));
    for (int i = 0; i < 40 && !(m_valid && m_data == 16'h00D7); i++) step();
    chk("t5_eighth_last", m_last, 1);
    wait_drain(20);

    // Underflow pulse is sticky until reset.
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    chk("t6_err_set", err_underflow, 1);
    repeat (3) step();
    chk("t6_err_held", err_underflow, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_err_cleared", err_underflow, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
